// File: rtl/w0rm_core_alu_writeback_pkg.sv
// Shared definitions for the W0RM ALU writeback stage: flag bit positions
// and the layout of the in-order completion tag {dest, write_en, mask}.
package w0rm_core_alu_writeback_pkg;

    // Architectural flags register layout {Z,N,V,C}, MSB..LSB.
    localparam int NUM_FLAGS = 4;
    localparam int FLAG_Z    = 3;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 1;
    localparam int FLAG_C    = 0;

    // Tag layout: the flag mask sits in the low bits, write_en above it,
    // and the destination register index at the top.
    localparam int TAG_MASK_LSB = 0;

    function automatic int tag_we_bit(input int flags_w);
        return TAG_MASK_LSB + flags_w;
    endfunction

    function automatic int tag_dest_lsb(input int flags_w);
        return tag_we_bit(flags_w) + 1;
    endfunction

    function automatic int tag_width(input int addr_w, input int flags_w);
        return addr_w + 1 + flags_w;
    endfunction

endpackage

// File: rtl/w0rm_sync_fifo.sv
// Small synchronous FIFO holding in-flight op tags. The head entry is read
// asynchronously so a completing result can be paired with its tag in the
// same cycle. A push while full or a pop while empty is ignored.
module w0rm_sync_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_WIDTH-1:0]          push_data,
    input  logic                           pop,
    output logic [DATA_WIDTH-1:0]          pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/w0rm_core_alu_writeback.sv
// Writeback stage behind the multi-cycle W0RM ALU. Tags captured at issue
// are paired in order with ALU results; the pair drives a registered
// register-file write port and a masked update of the flags register.
// A per-register busy scoreboard tells the issue stage which registers
// still have a write outstanding.
module w0rm_core_alu_writeback
    import w0rm_core_alu_writeback_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int FLAGS_WIDTH    = NUM_FLAGS,
    parameter int TAG_DEPTH      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              issue_valid,
    output logic                              issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0]         issue_dest,
    input  logic                              issue_write_en,
    input  logic [FLAGS_WIDTH-1:0]            issue_flags_mask,
    input  logic                              alu_result_valid,
    input  logic [DATA_WIDTH-1:0]             alu_result,
    input  logic                              alu_flag_zero,
    input  logic                              alu_flag_negative,
    input  logic                              alu_flag_overflow,
    input  logic                              alu_flag_carry,
    output logic                              rf_write_en,
    output logic [REG_ADDR_WIDTH-1:0]         rf_write_addr,
    output logic [DATA_WIDTH-1:0]             rf_write_data,
    output logic [FLAGS_WIDTH-1:0]            flags,
    output logic [(2**REG_ADDR_WIDTH)-1:0]    reg_busy,
    output logic [$clog2(TAG_DEPTH+1)-1:0]    pending_count,
    output logic                              error
);

    localparam int NUM_REGS  = 2 ** REG_ADDR_WIDTH;
    localparam int TAG_W     = tag_width(REG_ADDR_WIDTH, FLAGS_WIDTH);
    localparam int WE_BIT    = tag_we_bit(FLAGS_WIDTH);
    localparam int DEST_LSB  = tag_dest_lsb(FLAGS_WIDTH);

    logic [TAG_W-1:0]            push_tag;
    logic [TAG_W-1:0]            head_tag;
    logic [REG_ADDR_WIDTH-1:0]   head_dest;
    logic                        head_we;
    logic [FLAGS_WIDTH-1:0]      head_mask;
    logic                        fifo_full;
    logic                        fifo_empty;

    logic                        issue_accept;
    logic                        issue_drop;
    logic                        waw_hazard;
    logic                        orphan_result;
    logic                        result_pop;
    logic [FLAGS_WIDTH-1:0]      alu_flags;

    logic                        rf_write_en_reg;
    logic [REG_ADDR_WIDTH-1:0]   rf_write_addr_reg;
    logic [DATA_WIDTH-1:0]       rf_write_data_reg;
    logic [FLAGS_WIDTH-1:0]      flags_reg;
    logic [NUM_REGS-1:0]         reg_busy_reg;
    logic                        error_reg;

    // A slot freed by a pop only becomes visible the next cycle, so ready
    // depends on registered occupancy alone.
    assign issue_ready   = ~fifo_full;
    assign issue_accept  = issue_valid & issue_ready;
    assign issue_drop    = issue_valid & ~issue_ready;
    assign waw_hazard    = issue_accept & issue_write_en & reg_busy_reg[issue_dest];
    assign orphan_result = alu_result_valid & fifo_empty;
    assign result_pop    = alu_result_valid & ~fifo_empty;

    assign push_tag  = {issue_dest, issue_write_en, issue_flags_mask};
    assign head_dest = head_tag[DEST_LSB +: REG_ADDR_WIDTH];
    assign head_we   = head_tag[WE_BIT];
    assign head_mask = head_tag[TAG_MASK_LSB +: FLAGS_WIDTH];

    w0rm_sync_fifo #(
        .DATA_WIDTH (TAG_W),
        .DEPTH      (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (issue_accept),
        .push_data (push_tag),
        .pop       (result_pop),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (pending_count)
    );

    // Gather the individual ALU flag lines into the architectural layout.
    always_comb begin
        alu_flags         = '0;
        alu_flags[FLAG_Z] = alu_flag_zero;
        alu_flags[FLAG_N] = alu_flag_negative;
        alu_flags[FLAG_V] = alu_flag_overflow;
        alu_flags[FLAG_C] = alu_flag_carry;
    end

    // Register-file write port: one cycle after the result is paired with its tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_en_reg   <= 1'b0;
            rf_write_addr_reg <= '0;
            rf_write_data_reg <= '0;
        end else begin
            rf_write_en_reg <= result_pop & head_we;
            if (result_pop) begin
                rf_write_addr_reg <= head_dest;
                rf_write_data_reg <= alu_result;
            end
        end
    end

    // Flags register: each bit updates only where the completing op's mask asks for it.
    generate
        for (genvar gi = 0; gi < FLAGS_WIDTH; gi++) begin : g_flag
            always_ff @(posedge clk) begin
                if (reset) begin
                    flags_reg[gi] <= 1'b0;
                end else if (result_pop && head_mask[gi]) begin
                    flags_reg[gi] <= alu_flags[gi];
                end
            end
        end
    endgenerate

    // Busy scoreboard: set on issue, cleared as the RF commits; a new issue wins a same-edge clear.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            logic busy_set;
            logic busy_clr;
            assign busy_set = issue_accept & issue_write_en &
                              (issue_dest == REG_ADDR_WIDTH'(gi));
            assign busy_clr = rf_write_en_reg &
                              (rf_write_addr_reg == REG_ADDR_WIDTH'(gi));
            always_ff @(posedge clk) begin
                if (reset) begin
                    reg_busy_reg[gi] <= 1'b0;
                end else if (busy_set) begin
                    reg_busy_reg[gi] <= 1'b1;
                end else if (busy_clr) begin
                    reg_busy_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Sticky protocol error: dropped issue, WAW issue or a result with no tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else if (issue_drop || waw_hazard || orphan_result) begin
            error_reg <= 1'b1;
        end
    end

    assign rf_write_en   = rf_write_en_reg;
    assign rf_write_addr = rf_write_addr_reg;
    assign rf_write_data = rf_write_data_reg;
    assign flags         = flags_reg;
    assign reg_busy      = reg_busy_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_w0rm_core_alu_writeback.sv
// Directed bench for the ALU writeback stage. Expected register writes are
// queued when a result is driven; a monitor pops and compares them whenever
// the DUT strobes its register-file write port. Status outputs are checked
// inline after each step.
module tb_w0rm_core_alu_writeback;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_dest;
    logic        issue_write_en;
    logic [3:0]  issue_flags_mask;
    logic        alu_result_valid;
    logic [31:0] alu_result;
    logic        alu_flag_zero;
    logic        alu_flag_negative;
    logic        alu_flag_overflow;
    logic        alu_flag_carry;
    logic        rf_write_en;
    logic [3:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [3:0]  flags;
    logic [15:0] reg_busy;
    logic [2:0]  pending_count;
    logic        error;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;

    w0rm_core_alu_writeback dut (
        .clk               (clk),
        .reset             (reset),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_dest        (issue_dest),
        .issue_write_en    (issue_write_en),
        .issue_flags_mask  (issue_flags_mask),
        .alu_result_valid  (alu_result_valid),
        .alu_result        (alu_result),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_negative (alu_flag_negative),
        .alu_flag_overflow (alu_flag_overflow),
        .alu_flag_carry    (alu_flag_carry),
        .rf_write_en       (rf_write_en),
        .rf_write_addr     (rf_write_addr),
        .rf_write_data     (rf_write_data),
        .flags             (flags),
        .reg_busy          (reg_busy),
        .pending_count     (pending_count),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every RF write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_write_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: act=r%0d=%0h req=none", rf_write_addr, rf_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (rf_write_addr !== e.addr || rf_write_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rf_write: act=r%0d=%0h req=r%0d=%0h",
                             rf_write_addr, rf_write_data, e.addr, e.data);
                end else begin
                    $display("ok   rf_write: r%0d=%0h", rf_write_addr, rf_write_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid       = 1'b0;
        issue_dest        = '0;
        issue_write_en    = 1'b0;
        issue_flags_mask  = '0;
        alu_result_valid  = 1'b0;
        alu_result        = '0;
        alu_flag_zero     = 1'b0;
        alu_flag_negative = 1'b0;
        alu_flag_overflow = 1'b0;
        alu_flag_carry    = 1'b0;
    endtask

    task automatic drive_issue(input logic [3:0] dest, input logic we, input logic [3:0] mask);
        issue_valid      = 1'b1;
        issue_dest       = dest;
        issue_write_en   = we;
        issue_flags_mask = mask;
    endtask

    // Drive a result; when expect_write is set, queue the RF write it must produce.
    task automatic drive_result(input logic [31:0] data, input logic [3:0] f,
                                input logic expect_write, input logic [3:0] addr);
        wr_t e;
        alu_result_valid  = 1'b1;
        alu_result        = data;
        alu_flag_zero     = f[3];
        alu_flag_negative = f[2];
        alu_flag_overflow = f[1];
        alu_flag_carry    = f[0];
        if (expect_write) begin
            e.addr = addr;
            e.data = data;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();

        // Reset state
        check("rst_pending", 32'(pending_count), 32'd0);
        check("rst_ready",   32'(issue_ready),   32'd1);
        check("rst_busy",    32'(reg_busy),      32'd0);
        check("rst_flags",   32'(flags),         32'd0);
        check("rst_error",   32'(error),         32'd0);
        check("rst_wen",     32'(rf_write_en),   32'd0);

        // 1: single op to r3, result 0 with Z three cycles after issue
        drive_issue(4'd3, 1'b1, 4'hF);
        tick();
        idle();
        check("t1_busy_set", 32'(reg_busy[3]),  32'd1);
        check("t1_pending",  32'(pending_count), 32'd1);
        tick();
        tick();
        drive_result(32'h0, 4'b1000, 1'b1, 4'd3);
        tick();
        idle();
        check("t1_wen",      32'(rf_write_en),  32'd1);
        check("t1_flags",    32'(flags),        32'h8);
        check("t1_busy_hold",32'(reg_busy[3]),  32'd1);
        check("t1_pending0", 32'(pending_count), 32'd0);
        tick();
        check("t1_busy_clr", 32'(reg_busy[3]),  32'd0);
        check("t1_wen_off",  32'(rf_write_en),  32'd0);

        // 2: r1, r2, r5 back to back, results overlapping the last issue; mask 0
        drive_issue(4'd1, 1'b1, 4'h0);
        tick();
        drive_issue(4'd2, 1'b1, 4'h0);
        tick();
        drive_issue(4'd5, 1'b1, 4'h0);
        drive_result(32'd1, 4'b0111, 1'b1, 4'd1);
        tick();
        idle();
        check("t2_busy", 32'(reg_busy), 32'h0026);
        drive_result(32'd2, 4'b0101, 1'b1, 4'd2);
        tick();
        drive_result(32'd5, 4'b0110, 1'b1, 4'd5);
        tick();
        idle();
        check("t2_flags_kept", 32'(flags), 32'h8);
        tick();
        check("t2_busy_clr", 32'(reg_busy), 32'h0);
        check("t2_pending",  32'(pending_count), 32'd0);

        // 3: compare-only op, mask {V,C}, ALU V=1 C=0 N=1
        drive_issue(4'd7, 1'b0, 4'b0011);
        tick();
        idle();
        check("t3_busy_none", 32'(reg_busy), 32'h0);
        drive_result(32'd7, 4'b0110, 1'b0, 4'd0);
        tick();
        idle();
        check("t3_no_wen", 32'(rf_write_en), 32'd0);
        check("t3_flags",  32'(flags),       32'hA);
        check("t3_error",  32'(error),       32'd0);

        // 4: fill all tags, then result and issue in the same cycle
        drive_issue(4'd4, 1'b1, 4'h0);
        tick();
        drive_issue(4'd6, 1'b1, 4'h0);
        tick();
        drive_issue(4'd7, 1'b1, 4'h0);
        tick();
        drive_issue(4'd8, 1'b1, 4'h0);
        tick();
        idle();
        check("t4_ready_full", 32'(issue_ready),   32'd0);
        check("t4_pending4",   32'(pending_count), 32'd4);
        drive_issue(4'd9, 1'b1, 4'h0);
        drive_result(32'd44, 4'b0000, 1'b1, 4'd4);
        tick();
        idle();
        check("t4_error",    32'(error),         32'd1);
        check("t4_ready",    32'(issue_ready),   32'd1);
        check("t4_pending3", 32'(pending_count), 32'd3);
        check("t4_r9_idle",  32'(reg_busy[9]),   32'd0);
        drive_result(32'd66, 4'b0000, 1'b1, 4'd6);
        tick();
        drive_result(32'd77, 4'b0000, 1'b1, 4'd7);
        tick();
        drive_result(32'd88, 4'b0000, 1'b1, 4'd8);
        tick();
        idle();
        tick();
        check("t4_drain_pending", 32'(pending_count), 32'd0);
        check("t4_drain_busy",    32'(reg_busy),      32'h0);

        // 5: result with no tag pending
        do_reset();
        check("t5_error_pre", 32'(error), 32'd0);
        drive_result(32'h1234, 4'b1111, 1'b0, 4'd0);
        tick();
        idle();
        check("t5_no_wen",  32'(rf_write_en), 32'd0);
        check("t5_error",   32'(error),       32'd1);
        check("t5_flags",   32'(flags),       32'd0);
        tick();
        tick();
        tick();
        check("t5_error_sticky", 32'(error), 32'd1);

        // 6: reset with two tags pending and nonzero flags
        drive_issue(4'd0, 1'b0, 4'hF);
        tick();
        idle();
        drive_result(32'd0, 4'b1111, 1'b0, 4'd0);
        tick();
        idle();
        check("t6_flags_set", 32'(flags), 32'hF);
        drive_issue(4'd2, 1'b1, 4'h0);
        tick();
        drive_issue(4'd10, 1'b1, 4'h0);
        tick();
        idle();
        check("t6_pending2", 32'(pending_count), 32'd2);
        check("t6_busy2",    32'(reg_busy),      32'h0404);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_pending0", 32'(pending_count), 32'd0);
        check("t6_busy0",    32'(reg_busy),      32'h0);
        check("t6_flags0",   32'(flags),         32'h0);
        check("t6_error0",   32'(error),         32'd0);
        check("t6_ready",    32'(issue_ready),   32'd1);
        tick();
        tick();

        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
